usb_tx: RTL

- USB full-speed style packet transmitter; the transmit-side counterpart of the d_plus/d_minus receive path (edge detect, NRZI decode, destuff).
- Accepts bytes over a valid/ready handshake, then drives the line: SYNC, data bytes LSB-first, bit stuffing, NRZI encoding, EOP.
- Sits between the packet/protocol controller and the bus line drivers.

---
 rtl/usb_tx_pkg.sv | 12 +
 rtl/usb_tx_bit_timer.sv | 19 +
 rtl/usb_tx.sv | 113 +++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared states, line levels and NRZI helper for the USB transmitter
package usb_tx_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} tx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [1:0] LINE_J = 2'b10;
  localparam logic [1:0] LINE_K = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam int EOP_SE0_BITS = 2;
  function automatic logic [1:0] nrzi(input logic [1:0] l, input logic b);
    return b ? l : (l == LINE_J ? LINE_K : LINE_J);
  endfunction
endpackage

// File: rtl/usb_tx_bit_timer.sv
// usb_tx_bit_timer: bit period counter pulsing bit_strobe on the last cycle of each period
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_strobe
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_strobe = en && !clr && cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= bit_strobe ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter with SYNC, bit stuffing, NRZI and EOP
module usb_tx
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_error
);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  tx_state_t state, state_n;
  logic [1:0] line, line_n;
  logic [7:0] shreg, shreg_n, hold_data, src;
  logic [3:0] bit_cnt, bit_cnt_n, src_cnt;
  logic [OW-1:0] ones, ones_n;
  logic hold_full, hold_last, cur_last, cur_last_n, err_n, strobe, accept, load, stuff;
  usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk), .rst(rst), .clr(state == IDLE), .en(1'b1), .bit_strobe(strobe)
  );
  assign tx_ready = !hold_full && (state == IDLE || state == SYNC || state == DATA);
  assign accept = tx_valid && tx_ready;
  assign stuff = ones == OW'(STUFF_LIMIT);
  assign load = strobe && bit_cnt == 4'd8 && (state == SYNC || (state == DATA && !cur_last && hold_full));
  assign src = load ? hold_data : shreg;
  assign src_cnt = load ? 4'd0 : bit_cnt;
  assign {d_plus, d_minus} = line;
  assign tx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    line_n = line;
    shreg_n = shreg;
    bit_cnt_n = bit_cnt;
    ones_n = ones;
    cur_last_n = cur_last;
    err_n = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        state_n = SYNC;
        line_n = nrzi(line, SYNC_BYTE[0]);
        shreg_n = SYNC_BYTE >> 1;
        bit_cnt_n = 4'd1;
        ones_n = '0;
      end
    end else if (strobe) begin
      if (state == SYNC || state == DATA) begin
        if (load) begin
          state_n = DATA;
          cur_last_n = hold_last;
        end
        if (!stuff && src_cnt == 4'd8) begin
          state_n = EOP_SE0;
          line_n = LINE_SE0;
          bit_cnt_n = '0;
          err_n = !cur_last;
        end else if (stuff) begin
          line_n = nrzi(line, 1'b0);
          ones_n = '0;
          shreg_n = src;
          bit_cnt_n = src_cnt;
        end else begin
          line_n = nrzi(line, src[0]);
          ones_n = src[0] ? ones + OW'(1) : '0;
          shreg_n = src >> 1;
          bit_cnt_n = src_cnt + 4'd1;
        end
      end else if (state == EOP_SE0) begin
        if (bit_cnt == 4'(EOP_SE0_BITS - 1)) begin
          state_n = EOP_J;
          line_n = LINE_J;
        end else bit_cnt_n = bit_cnt + 4'd1;
      end else begin
        state_n = IDLE;
        line_n = LINE_J;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      line <= LINE_J;
      shreg <= '0;
      bit_cnt <= '0;
      ones <= '0;
      cur_last <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state <= state_n;
      line <= line_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
      ones <= ones_n;
      cur_last <= cur_last_n;
      tx_error <= err_n;
      hold_full <= accept || (hold_full && !load);
      if (accept) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
      end
    end
  end
endmodule
